// File: rtl/lazy_select_pipeline.sv
// lazy_select_pipeline
//   Picks the best of LAZY_LEN candidate matches at consecutive positions,
//   scored by gain, and emits one sequence (ll/ml/offset) together with the
//   job-advance information. The pipeline is 3 + log2(LAZY_LEN) stages deep
//   and accepts one request per cycle. It has full valid/ready backpressure:
//   every stage holds while the output is valid and the consumer is not ready.
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     i_valid / o_ready     request handshake
//     i_match_head_ptr      position of candidate 0
//     i_seq_head_ptr        start of pending literals
//     i_delim               last job of a block
//     i_match_valid         per-candidate valid
//     i_match_len           packed lengths, slice i = candidate i
//     i_offset              packed offsets, slice i = candidate i
//     o_valid / i_ready     summary handshake
//     o_seq_head_ptr        echoed seq head
//     o_ll, o_ml, o_offset  chosen sequence
//     o_delim, o_eoj, o_move_to_next_job  flags
//     o_overlap_len         match bytes spilling into the next job
//     o_move_forward        seq-head advance within the job
//
//   Optional feature macro: LAZY_SELECT_STATS_EN
//     Adds o_stat_seq_cnt / o_stat_eoj_cnt, two saturating 32-bit counters
//     of emitted sequences and of emitted end-of-job sequences.
module lazy_select_pipeline #(
   parameter int        LAZY_LEN        = 4,
   parameter int        MATCH_LEN_WIDTH = 11,
   parameter int        OFFSET_BITS     = 16,
   parameter int        JOB_LEN_LOG2    = 12,
   parameter int        LL_BITS         = 16,
   parameter int        ML_BITS         = 16,
   parameter int signed INVALID_GAIN    = -64
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_valid,
   output logic                                 o_ready,
   input  logic [JOB_LEN_LOG2-1:0]              i_match_head_ptr,
   input  logic [JOB_LEN_LOG2-1:0]              i_seq_head_ptr,
   input  logic                                 i_delim,
   input  logic [LAZY_LEN-1:0]                  i_match_valid,
   input  logic [LAZY_LEN*MATCH_LEN_WIDTH-1:0]  i_match_len,
   input  logic [LAZY_LEN*OFFSET_BITS-1:0]      i_offset,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic [JOB_LEN_LOG2-1:0]              o_seq_head_ptr,
   output logic [LL_BITS-1:0]                   o_ll,
   output logic [ML_BITS-1:0]                   o_ml,
   output logic [OFFSET_BITS-1:0]               o_offset,
   output logic                                 o_delim,
   output logic                                 o_eoj,
   output logic                                 o_move_to_next_job,
   output logic [ML_BITS-1:0]                   o_overlap_len,
   output logic [JOB_LEN_LOG2-1:0]              o_move_forward
`ifdef LAZY_SELECT_STATS_EN
   ,
   output logic [31:0]                          o_stat_seq_cnt,
   output logic [31:0]                          o_stat_eoj_cnt
`endif
);

   localparam int LOG     = $clog2(LAZY_LEN);
   localparam int D       = 3 + LOG;
   localparam int NN      = 2 * LAZY_LEN;
   localparam int LLW     = JOB_LEN_LOG2 + 1;
   localparam int MLW     = MATCH_LEN_WIDTH;
   localparam int OBW     = $clog2(OFFSET_BITS + 1);
   localparam int GW      = MATCH_LEN_WIDTH + 3;
   localparam int FW      = ((LLW > MLW) ? LLW : MLW) + 1;
   localparam int OW      = FW + 2;
   localparam int JOB_LEN = 2 ** JOB_LEN_LOG2;

   // ---------------- handshake ----------------
   logic vld_q [D];
   logic rdy_q;
   logic adv;
   logic accept;

   assign adv     = !vld_q[D-1] || i_ready;
   assign o_ready = adv && rdy_q;
   assign accept  = i_valid && o_ready;
   assign o_valid = vld_q[D-1];

   // o_ready stays low for the first cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < D; k++) vld_q[k] <= 1'b0;
      end else if (adv) begin
         vld_q[0] <= accept;
         for (int k = 1; k < D; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   // ---------------- side-band carried to the final stage ----------------
   logic [JOB_LEN_LOG2-1:0] hs_q    [D-1];
   logic                    delim_q [D-1];
   logic [LLW-1:0]          lln_q   [D-1];
   logic [LLW-1:0]          lln_d;

   // literal length if no candidate is taken: position just past the window
   assign lln_d = LLW'(i_match_head_ptr) - LLW'(i_seq_head_ptr) + LLW'(LAZY_LEN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < D-1; k++) begin
            hs_q[k]    <= '0;
            delim_q[k] <= 1'b0;
            lln_q[k]   <= '0;
         end
      end else if (adv) begin
         hs_q[0]    <= i_seq_head_ptr;
         delim_q[0] <= i_delim;
         lln_q[0]   <= lln_d;
         for (int k = 1; k < D-1; k++) begin
            hs_q[k]    <= hs_q[k-1];
            delim_q[k] <= delim_q[k-1];
            lln_q[k]   <= lln_q[k-1];
         end
      end
   end

   // ---------------- S0: literal length and offset bit length ----------------
   logic [LLW-1:0]         s0_ll_d  [LAZY_LEN];
   logic [OBW-1:0]         s0_ob_d  [LAZY_LEN];
   logic [LLW-1:0]         s0_ll_q  [LAZY_LEN];
   logic [OBW-1:0]         s0_ob_q  [LAZY_LEN];
   logic [MLW-1:0]         s0_ml_q  [LAZY_LEN];
   logic [OFFSET_BITS-1:0] s0_off_q [LAZY_LEN];
   logic [LAZY_LEN-1:0]    s0_mv_q;

   always_comb begin
      for (int i = 0; i < LAZY_LEN; i++) begin
         s0_ll_d[i] = LLW'(i_match_head_ptr) - LLW'(i_seq_head_ptr) + LLW'(i);
         s0_ob_d[i] = '0;
         for (int b = 0; b < OFFSET_BITS; b++) begin
            if (i_offset[i*OFFSET_BITS + b]) s0_ob_d[i] = OBW'(b + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAZY_LEN; i++) begin
            s0_ll_q[i]  <= '0;
            s0_ob_q[i]  <= '0;
            s0_ml_q[i]  <= '0;
            s0_off_q[i] <= '0;
         end
         s0_mv_q <= '0;
      end else if (adv) begin
         for (int i = 0; i < LAZY_LEN; i++) begin
            s0_ll_q[i]  <= s0_ll_d[i];
            s0_ob_q[i]  <= s0_ob_d[i];
            s0_ml_q[i]  <= i_match_len[i*MLW +: MLW];
            s0_off_q[i] <= i_offset[i*OFFSET_BITS +: OFFSET_BITS];
         end
         s0_mv_q <= i_match_valid;
      end
   end

   // ---------------- S1 leaves and compare tree ----------------
   // Heap layout: node 1 is the root, children of n are 2n and 2n+1, leaves
   // are LAZY_LEN..2*LAZY_LEN-1 with candidate i at LAZY_LEN+i. The left
   // child always covers lower candidate indices, so "right wins only when
   // strictly greater" gives the lower index on a tie.
   logic signed [GW-1:0]   leaf_gain_d [LAZY_LEN];
   logic [FW-1:0]          leaf_fwd_d  [LAZY_LEN];
   logic                   win_r       [1:LAZY_LEN-1];

   logic                   nd_v_q    [1:NN-1];
   logic signed [GW-1:0]   nd_gain_q [1:NN-1];
   logic [LLW-1:0]         nd_ll_q   [1:NN-1];
   logic [MLW-1:0]         nd_ml_q   [1:NN-1];
   logic [OFFSET_BITS-1:0] nd_off_q  [1:NN-1];
   logic [FW-1:0]          nd_fwd_q  [1:NN-1];

   always_comb begin
      for (int i = 0; i < LAZY_LEN; i++) begin
         if (s0_mv_q[i])
            leaf_gain_d[i] = $signed({1'b0, s0_ml_q[i], 2'b00} + GW'(4 * (LAZY_LEN - i))
                                     - GW'(s0_ob_q[i]));
         else
            leaf_gain_d[i] = GW'(INVALID_GAIN);
         leaf_fwd_d[i] = FW'(s0_ll_q[i]) + FW'(s0_ml_q[i]);
      end
   end

   always_comb begin
      for (int n = 1; n < LAZY_LEN; n++) begin
         win_r[n] = nd_gain_q[2*n+1] > nd_gain_q[2*n];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 1; n < NN; n++) begin
            nd_v_q[n]    <= 1'b0;
            nd_gain_q[n] <= '0;
            nd_ll_q[n]   <= '0;
            nd_ml_q[n]   <= '0;
            nd_off_q[n]  <= '0;
            nd_fwd_q[n]  <= '0;
         end
      end else if (adv) begin
         for (int i = 0; i < LAZY_LEN; i++) begin
            nd_v_q[LAZY_LEN+i]    <= s0_mv_q[i];
            nd_gain_q[LAZY_LEN+i] <= leaf_gain_d[i];
            nd_ll_q[LAZY_LEN+i]   <= s0_ll_q[i];
            nd_ml_q[LAZY_LEN+i]   <= s0_ml_q[i];
            nd_off_q[LAZY_LEN+i]  <= s0_off_q[i];
            nd_fwd_q[LAZY_LEN+i]  <= leaf_fwd_d[i];
         end
         for (int n = 1; n < LAZY_LEN; n++) begin
            nd_v_q[n] <= nd_v_q[2*n] || nd_v_q[2*n+1];
            if (win_r[n]) begin
               nd_gain_q[n] <= nd_gain_q[2*n+1];
               nd_ll_q[n]   <= nd_ll_q[2*n+1];
               nd_ml_q[n]   <= nd_ml_q[2*n+1];
               nd_off_q[n]  <= nd_off_q[2*n+1];
               nd_fwd_q[n]  <= nd_fwd_q[2*n+1];
            end else begin
               nd_gain_q[n] <= nd_gain_q[2*n];
               nd_ll_q[n]   <= nd_ll_q[2*n];
               nd_ml_q[n]   <= nd_ml_q[2*n];
               nd_off_q[n]  <= nd_off_q[2*n];
               nd_fwd_q[n]  <= nd_fwd_q[2*n];
            end
         end
      end
   end

   // ---------------- final stage: job boundary handling ----------------
   logic [LLW-1:0]          sel_ll;
   logic [MLW-1:0]          sel_ml;
   logic [OFFSET_BITS-1:0]  sel_off;
   logic [FW-1:0]           sel_fwd;
   logic [OW-1:0]           ovl;
   logic [JOB_LEN_LOG2-1:0] fin_hs;

   logic [LL_BITS-1:0]      ll_d,  ll_q;
   logic [ML_BITS-1:0]      ml_d,  ml_q;
   logic [OFFSET_BITS-1:0]  off_d, off_q;
   logic [ML_BITS-1:0]      ovl_d, ovl_q;
   logic [JOB_LEN_LOG2-1:0] mf_d,  mf_q;
   logic                    eoj_d, eoj_q;
   logic [JOB_LEN_LOG2-1:0] sh_q;
   logic                    dlm_q;

   assign fin_hs = hs_q[D-2];

   always_comb begin
      if (nd_v_q[1]) begin
         sel_ll  = nd_ll_q[1];
         sel_ml  = nd_ml_q[1];
         sel_off = nd_off_q[1];
         sel_fwd = nd_fwd_q[1];
      end else begin
         sel_ll  = lln_q[D-2];
         sel_ml  = '0;
         sel_off = '0;
         sel_fwd = FW'(lln_q[D-2]);
      end
      // two's complement; MSB set means the match ends inside this job
      ovl = OW'(fin_hs) + OW'(sel_fwd) - OW'(JOB_LEN);

      ll_d  = LL_BITS'(sel_ll);
      ml_d  = ML_BITS'(sel_ml);
      off_d = sel_off;
      ovl_d = '0;
      mf_d  = sel_fwd[JOB_LEN_LOG2-1:0];
      eoj_d = 1'b0;
      if (!ovl[OW-1]) begin
         eoj_d = 1'b1;
         mf_d  = '0;
         if (delim_q[D-2]) begin
            // last job of the block: flush remaining literals, drop the match
            ll_d  = LL_BITS'(LLW'(JOB_LEN) - LLW'(fin_hs));
            ml_d  = '0;
            off_d = '0;
         end else begin
            ovl_d = ML_BITS'(ovl);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ll_q  <= '0;
         ml_q  <= '0;
         off_q <= '0;
         ovl_q <= '0;
         mf_q  <= '0;
         eoj_q <= 1'b0;
         sh_q  <= '0;
         dlm_q <= 1'b0;
      end else if (adv) begin
         ll_q  <= ll_d;
         ml_q  <= ml_d;
         off_q <= off_d;
         ovl_q <= ovl_d;
         mf_q  <= mf_d;
         eoj_q <= eoj_d;
         sh_q  <= fin_hs;
         dlm_q <= delim_q[D-2];
      end
   end

   assign o_seq_head_ptr     = sh_q;
   assign o_ll               = ll_q;
   assign o_ml               = ml_q;
   assign o_offset           = off_q;
   assign o_delim            = dlm_q;
   assign o_eoj              = eoj_q;
   assign o_move_to_next_job = eoj_q;
   assign o_overlap_len      = ovl_q;
   assign o_move_forward     = mf_q;

`ifdef LAZY_SELECT_STATS_EN
   logic [31:0] stat_seq_q;
   logic [31:0] stat_eoj_q;
   logic        pop;

   assign pop = vld_q[D-1] && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_seq_q <= '0;
         stat_eoj_q <= '0;
      end else if (pop) begin
         if (stat_seq_q != '1)          stat_seq_q <= stat_seq_q + 32'd1;
         if (eoj_q && stat_eoj_q != '1) stat_eoj_q <= stat_eoj_q + 32'd1;
      end
   end

   assign o_stat_seq_cnt = stat_seq_q;
   assign o_stat_eoj_cnt = stat_eoj_q;
`endif

endmodule

// File: tb/tb_lazy_select_pipeline.sv
// Testbench for lazy_select_pipeline (default parameters, JOB_LEN = 4096).
// Directed cases with hand-computed expectations, then randomized traffic
// scored against a behavioural model of the selection rules.
module tb_lazy_select_pipeline;

   localparam int L       = 4;
   localparam int MLW     = 11;
   localparam int OB      = 16;
   localparam int JLL     = 12;
   localparam int D       = 5;
   localparam int JOB_LEN = 4096;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               i_valid;
   logic               o_ready;
   logic [JLL-1:0]     i_match_head_ptr;
   logic [JLL-1:0]     i_seq_head_ptr;
   logic               i_delim;
   logic [L-1:0]       i_match_valid;
   logic [L*MLW-1:0]   i_match_len;
   logic [L*OB-1:0]    i_offset;
   logic               o_valid;
   logic               i_ready;
   logic [JLL-1:0]     o_seq_head_ptr;
   logic [15:0]        o_ll;
   logic [15:0]        o_ml;
   logic [OB-1:0]      o_offset;
   logic               o_delim;
   logic               o_eoj;
   logic               o_move_to_next_job;
   logic [15:0]        o_overlap_len;
   logic [JLL-1:0]     o_move_forward;
`ifdef LAZY_SELECT_STATS_EN
   logic [31:0]        o_stat_seq_cnt;
   logic [31:0]        o_stat_eoj_cnt;
`endif

   lazy_select_pipeline dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_valid            (i_valid),
      .o_ready            (o_ready),
      .i_match_head_ptr   (i_match_head_ptr),
      .i_seq_head_ptr     (i_seq_head_ptr),
      .i_delim            (i_delim),
      .i_match_valid      (i_match_valid),
      .i_match_len        (i_match_len),
      .i_offset           (i_offset),
      .o_valid            (o_valid),
      .i_ready            (i_ready),
      .o_seq_head_ptr     (o_seq_head_ptr),
      .o_ll               (o_ll),
      .o_ml               (o_ml),
      .o_offset           (o_offset),
      .o_delim            (o_delim),
      .o_eoj              (o_eoj),
      .o_move_to_next_job (o_move_to_next_job),
      .o_overlap_len      (o_overlap_len),
      .o_move_forward     (o_move_forward)
`ifdef LAZY_SELECT_STATS_EN
      ,
      .o_stat_seq_cnt     (o_stat_seq_cnt),
      .o_stat_eoj_cnt     (o_stat_eoj_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int   hm;
      int   hs;
      bit   delim;
      bit [L-1:0] mv;
      int   ml  [L];
      int   off [L];
   } req_t;

   typedef struct {
      int ll, ml, off, ovl, mf, sh;
      bit delim, eoj;
      int acc_cyc;
      bit meas;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   pops  = 0;
   int   eoj_pops = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int bitlen(input int v);
      int n = 0;
      while (v > 0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

   // Behavioural reference: score every valid candidate, keep the first
   // strictly best one, then apply the job-boundary rules.
   function automatic exp_t model(input req_t r);
      exp_t e;
      int best = -1;
      int bg   = 0;
      int g, ll, fwd, ovl;
      for (int i = 0; i < L; i++) begin
         if (r.mv[i]) begin
            g = 4 * r.ml[i] + 4 * (L - i) - bitlen(r.off[i]);
            if (best < 0 || g > bg) begin
               best = i;
               bg   = g;
            end
         end
      end
      if (best < 0) begin
         ll    = r.hm - r.hs + L;
         e.ml  = 0;
         e.off = 0;
         fwd   = ll;
      end else begin
         ll    = r.hm - r.hs + best;
         e.ml  = r.ml[best];
         e.off = r.off[best];
         fwd   = ll + e.ml;
      end
      ovl     = r.hs + fwd - JOB_LEN;
      e.sh    = r.hs;
      e.delim = r.delim;
      e.acc_cyc = 0;
      e.meas  = 1'b0;
      if (ovl >= 0) begin
         e.eoj = 1'b1;
         e.mf  = 0;
         if (r.delim) begin
            ll    = JOB_LEN - r.hs;
            e.ml  = 0;
            e.off = 0;
            e.ovl = 0;
         end else begin
            e.ovl = ovl;
         end
      end else begin
         e.eoj = 1'b0;
         e.ovl = 0;
         e.mf  = fwd % JOB_LEN;
      end
      e.ll = ll;
      return e;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int   nb;
      r.hs = $urandom_range(0, 1) ? int'($urandom_range(3990, 4095)) : int'($urandom_range(0, 4095));
      r.hm = ($urandom_range(0, 1) != 0) ? int'($urandom_range(r.hs, 4095))
                                        : ((r.hs + int'($urandom_range(0, 20)) > 4095) ? 4095 : r.hs + int'($urandom_range(0, 20)));
      r.delim = ($urandom_range(0, 3) == 0);
      r.mv    = L'($urandom);
      for (int i = 0; i < L; i++) begin
         r.ml[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2043)) : int'($urandom_range(0, 40));
         nb = $urandom_range(0, 16);
         r.off[i] = (nb == 0) ? 0 : int'($urandom & ((32'd1 << nb) - 32'd1));
      end
      return r;
   endfunction

   function automatic req_t mk_req(input int hm, input int hs, input bit dl, input bit [L-1:0] mv,
                                   input int ml0, input int ml1, input int off0, input int off1);
      req_t r;
      r.hm = hm; r.hs = hs; r.delim = dl; r.mv = mv;
      for (int i = 0; i < L; i++) begin
         r.ml[i]  = 33 + i;
         r.off[i] = 7;
      end
      r.ml[0] = ml0; r.ml[1] = ml1; r.off[0] = off0; r.off[1] = off1;
      return r;
   endfunction

   function automatic exp_t mk_exp(input int ll, input int ml, input int off, input int ovl, input int mf,
                                   input int sh, input bit dl, input bit eoj);
      exp_t e;
      e.ll = ll; e.ml = ml; e.off = off; e.ovl = ovl; e.mf = mf; e.sh = sh;
      e.delim = dl; e.eoj = eoj; e.acc_cyc = 0; e.meas = 1'b0;
      return e;
   endfunction

   task automatic drive(input bit v, input req_t r, input bit rdy);
      i_valid          = v;
      i_ready          = rdy;
      i_match_head_ptr = JLL'(r.hm);
      i_seq_head_ptr   = JLL'(r.hs);
      i_delim          = r.delim;
      i_match_valid    = r.mv;
      for (int i = 0; i < L; i++) begin
         i_match_len[i*MLW +: MLW] = MLW'(r.ml[i]);
         i_offset[i*OB +: OB]      = OB'(r.off[i]);
      end
   endtask

   // One clock cycle: drive after the falling edge, sample 1 ns later,
   // score the output against the head of the expectation queue.
   task automatic cycle(input bit v, input req_t r, input bit rdy, input bit use_e,
                        input exp_t e, input bit meas, output bit acc);
      exp_t f;
      exp_t ee;
      @(negedge clk);
      drive(v, r, rdy);
      #1;
      cyc++;
      if (q.size() == 0) begin
         check("spurious_valid", o_valid, 0);
      end else if (o_valid) begin
         f = q[0];
         check("ll",      o_ll, f.ll);
         check("ml",      o_ml, f.ml);
         check("offset",  o_offset, f.off);
         check("overlap", o_overlap_len, f.ovl);
         check("move_fwd", o_move_forward, f.mf);
         check("seq_head", o_seq_head_ptr, f.sh);
         check("delim",   o_delim, f.delim);
         check("eoj",     o_eoj, f.eoj);
         check("next_job", o_move_to_next_job, f.eoj);
         if (i_ready) begin
            if (f.meas) check("latency", cyc - f.acc_cyc, D);
            pops++;
            if (f.eoj) eoj_pops++;
            void'(q.pop_front());
         end
      end
      acc = v && o_ready;
      if (acc) begin
         ee = use_e ? e : model(r);
         ee.acc_cyc = cyc;
         ee.meas    = meas;
         q.push_back(ee);
      end
   endtask

   exp_t dummy_e;
   req_t idle_r;

   task automatic send(input req_t r, input bit use_e, input exp_t e, input bit meas);
      bit acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, r, 1'b1, use_e, e, meas, acc);
      if (!acc) check("send_timeout", acc, 1);
   endtask

   task automatic drain();
      bit acc;
      for (int t = 0; t < 100 && q.size() > 0; t++) cycle(1'b0, idle_r, 1'b1, 1'b0, dummy_e, 1'b0, acc);
      check("drain_left", q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      bit   acc;
      int   sent;
      req_t burst[8];

      idle_r  = mk_req(0, 0, 1'b0, '0, 0, 0, 0, 0);
      dummy_e = mk_exp(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      rst_n = 1'b0;
      drive(1'b0, idle_r, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      check("rst_o_valid", o_valid, 0);
      check("rst_ll", o_ll, 0);
      check("rst_ml", o_ml, 0);
      check("rst_eoj", o_eoj, 0);
      check("rst_mf", o_move_forward, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_at_release", o_ready, 0);
      @(negedge clk);
      #1;
      check("ready_after_release", o_ready, 1);

      // gains 47 / 51, candidate 1 wins
      send(mk_req(0, 0, 1'b0, 4'b0011, 8, 10, 1, 1), 1'b1,
           mk_exp(1, 10, 1, 0, 11, 0, 1'b0, 1'b0), 1'b1);
      drain();
      // tie 45 / 45, lower index wins
      send(mk_req(0, 0, 1'b0, 4'b0011, 8, 9, 4, 4), 1'b1,
           mk_exp(0, 8, 4, 0, 8, 0, 1'b0, 1'b0), 1'b1);
      drain();
      // crosses the job end, no delimiter
      send(mk_req(4090, 4090, 1'b0, 4'b0001, 20, 0, 5, 0), 1'b1,
           mk_exp(0, 20, 5, 14, 0, 4090, 1'b0, 1'b1), 1'b1);
      drain();
      // crosses the job end, delimiter: literals flushed
      send(mk_req(4090, 4090, 1'b1, 4'b0001, 20, 0, 5, 0), 1'b1,
           mk_exp(6, 0, 0, 0, 0, 4090, 1'b1, 1'b1), 1'b1);
      drain();
      // no valid candidate
      send(mk_req(100, 100, 1'b0, 4'b0000, 50, 60, 9, 9), 1'b1,
           mk_exp(4, 0, 0, 0, 4, 100, 1'b0, 1'b0), 1'b1);
      drain();

      // backpressure: 8 requests, consumer stalled for 10 cycles
      for (int k = 0; k < 8; k++) burst[k] = rand_req();
      sent = 0;
      for (int t = 0; t < 10; t++) begin
         cycle(sent < 8, burst[sent < 8 ? sent : 0], 1'b0, 1'b0, dummy_e, 1'b0, acc);
         if (acc) sent++;
      end
      check("stall_accepts", sent, D);
      check("stall_o_ready", o_ready, 0);
      for (int t = 0; t < 40 && sent < 8; t++) begin
         cycle(1'b1, burst[sent], 1'b1, 1'b0, dummy_e, 1'b0, acc);
         if (acc) sent++;
      end
      check("burst_sent", sent, 8);
      drain();

      // reset with requests in flight
      for (int k = 0; k < 3; k++) send(rand_req(), 1'b0, dummy_e, 1'b0);
      check("inflight", q.size(), 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      q.delete();
      check("rst_mid_o_valid", o_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pops = 0;
      eoj_pops = 0;
      for (int t = 0; t < 8; t++) cycle(1'b0, idle_r, 1'b1, 1'b0, dummy_e, 1'b0, acc);
      send(rand_req(), 1'b0, dummy_e, 1'b0);
      send(rand_req(), 1'b0, dummy_e, 1'b0);
      drain();
      cycle(1'b0, idle_r, 1'b1, 1'b0, dummy_e, 1'b0, acc);
      check("post_rst_pops", pops, 2);
`ifdef LAZY_SELECT_STATS_EN
      check("stat_seq_post_rst", o_stat_seq_cnt, 2);
      check("stat_eoj_post_rst", o_stat_eoj_cnt, eoj_pops);
`endif

      // randomized traffic with random backpressure
      for (int t = 0; t < 500; t++) begin
         cycle($urandom_range(0, 3) != 0, rand_req(), $urandom_range(0, 3) != 0,
               1'b0, dummy_e, 1'b0, acc);
      end
      drain();
      cycle(1'b0, idle_r, 1'b1, 1'b0, dummy_e, 1'b0, acc);
`ifdef LAZY_SELECT_STATS_EN
      check("stat_seq", o_stat_seq_cnt, pops);
      check("stat_eoj", o_stat_eoj_cnt, eoj_pops);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
